// File: rtl/seq_div8.sv
// seq_div8: multi-cycle unsigned restoring divider, one trial subtraction per clock.
module seq_div8 #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] din1,
  input  logic [WIDTH-1:0] din2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] d_q, d_d, q_q, q_d, r_q, r_d, quo_q, quo_d, rem_q, rem_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic dbz_q, dbz_d;
  logic [WIDTH:0] t;
  logic [WIDTH+1:0] s;
  logic q_bit;
  // Divisor is zero-extended before inversion so the top sum bit is set exactly when T >= D.
  always_comb begin
    t = {r_q, q_q[WIDTH-1]};
    s = {1'b0, t} + {1'b0, ~{1'b0, d_q}} + (WIDTH+2)'(1);
    q_bit = s[WIDTH+1];
    state_d = state_q;
    d_d = d_q;
    q_d = q_q;
    r_d = r_q;
    cnt_d = cnt_q;
    quo_d = quo_q;
    rem_d = rem_q;
    dbz_d = dbz_q;
    if (state_q == CALC) begin
      r_d = q_bit ? s[WIDTH-1:0] : t[WIDTH-1:0];
      q_d = {q_q[WIDTH-2:0], q_bit};
      cnt_d = cnt_q + CNT_W'(1);
      if (cnt_q == CNT_W'(WIDTH-1)) begin
        state_d = DONE;
        quo_d = q_d;
        rem_d = r_d;
        dbz_d = 1'b0;
      end
    end else if (start) begin
      d_d = din2;
      q_d = din1;
      r_d = '0;
      cnt_d = '0;
      state_d = (din2 != '0) ? CALC : DONE;
      if (din2 == '0) begin
        quo_d = '1;
        rem_d = din1;
        dbz_d = 1'b1;
      end
    end else begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      d_q <= '0;
      q_q <= '0;
      r_q <= '0;
      cnt_q <= '0;
      quo_q <= '0;
      rem_q <= '0;
      dbz_q <= 1'b0;
    end else begin
      state_q <= state_d;
      d_q <= d_d;
      q_q <= q_d;
      r_q <= r_d;
      cnt_q <= cnt_d;
      quo_q <= quo_d;
      rem_q <= rem_d;
      dbz_q <= dbz_d;
    end
  end
  assign busy = (state_q == CALC);
  assign done = (state_q == DONE);
  assign quotient = quo_q;
  assign remainder = rem_q;
  assign div_by_zero = dbz_q;
endmodule

// File: tb/tb_seq_div8.sv
// tb_seq_div8: scoreboard bench for seq_div8; expected results queued at start, checked on done.
module tb_seq_div8;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [7:0] din1 = '0, din2 = '0;
  logic busy, done, div_by_zero;
  logic [7:0] quotient, remainder;
  typedef struct {logic [7:0] a; logic [7:0] b;} op_t;
  op_t sb[$];
  op_t e;
  int compared = 0, mismatched = 0, done_cnt = 0;

  seq_div8 dut (
    .clk(clk), .rst(rst), .start(start), .din1(din1), .din2(din2),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst && done) begin
      done_cnt++;
      if (sb.size() == 0) chk("spurious_done", 1, 0);
      else begin
        e = sb.pop_front();
        chk("dbz", div_by_zero, e.b == 0);
        chk("quotient", quotient, e.b == 0 ? 8'hff : e.a / e.b);
        chk("remainder", remainder, e.b == 0 ? e.a : e.a % e.b);
        if (e.b != 0) begin
          chk("invariant", 32'(quotient) * 32'(e.b) + 32'(remainder), 32'(e.a));
          chk("rem_lt_div", remainder < e.b, 1);
        end
      end
    end
  end

  task automatic run(input logic [7:0] a, input logic [7:0] b);
    int n;
    logic bs;
    sb.push_back('{a, b});
    din1 = a;
    din2 = b;
    start = 1'b1;
    step();
    start = 1'b0;
    n = 0;
    bs = busy;
    while (!done && n < 20) begin
      step();
      n++;
      bs |= busy;
    end
    chk("latency", n, b == 0 ? 0 : 8);
    chk("busy_seen", bs, b != 0);
    step();
  endtask

  initial begin
    int n, d0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_quo", quotient, 0);
    chk("rst_rem", remainder, 0);
    chk("rst_dbz", div_by_zero, 0);
    step();
    rst = 1'b0;
    step();
    run(100, 7);
    run(255, 1);
    run(5, 9);
    run(42, 0);
    d0 = done_cnt;
    sb.push_back('{200, 3});
    din1 = 200;
    din2 = 3;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (3) step();
    din1 = 9;
    din2 = 9;
    start = 1'b1;
    step();
    start = 1'b0;
    din1 = 0;
    n = 4;
    while (!done && n < 20) begin
      step();
      n++;
    end
    chk("ignore_latency", n, 8);
    repeat (12) step();
    chk("ignore_one_done", done_cnt - d0, 1);
    din1 = 100;
    din2 = 7;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (3) step();
    rst = 1'b1;
    #1;
    sb.delete();
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_quo", quotient, 0);
    chk("arst_rem", remainder, 0);
    chk("arst_dbz", div_by_zero, 0);
    d0 = done_cnt;
    step();
    rst = 1'b0;
    repeat (12) step();
    chk("arst_no_done", done_cnt - d0, 0);
    run(40, 6);
    for (int i = 0; i < 2000; i++) begin
      din1 = 8'($urandom_range(0, 255));
      din2 = 8'($urandom_range(0, 255));
      sb.push_back('{din1, din2});
      start = 1'b1;
      step();
      n = 0;
      while (!done && n < 20) begin
        step();
        n++;
      end
      chk("b2b_spacing", n, sb.size() == 0 && din2 == 0 ? 0 : (din2 == 0 ? 0 : 8));
    end
    start = 1'b0;
    repeat (4) step();
    chk("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
